// File: rtl/fib_pkg.sv
// Shared encodings for the Fibonacci sequencer: command opcodes and controller states.
package fib_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_STEP  = 2'd3
  } fib_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_sequencer_if.sv
// Command/status bundle between the Wishbone register block (master) and the sequencer (slave).
interface fib_sequencer_if #(
  parameter int unsigned WIDTH       = 30,
  parameter int unsigned CLOCK_WIDTH = 6,
  parameter int unsigned IDX_WIDTH   = 16
);
  import fib_pkg::*;

  logic                   cmd_valid;
  fib_op_e                cmd_op;
  logic [CLOCK_WIDTH-1:0] div_sel;
  logic [IDX_WIDTH-1:0]   target;
  logic                   irq_clr;

  logic [WIDTH-1:0]       fib_value;
  logic [IDX_WIDTH-1:0]   fib_index;
  logic                   busy;
  logic                   done;
  logic                   overflow;
  logic                   irq;

  modport master (
    output cmd_valid, cmd_op, div_sel, target, irq_clr,
    input  fib_value, fib_index, busy, done, overflow, irq
  );

  modport slave (
    input  cmd_valid, cmd_op, div_sel, target, irq_clr,
    output fib_value, fib_index, busy, done, overflow, irq
  );

endinterface

// File: rtl/fib_step_div.sv
// Step-rate divider: one-cycle tick every 2^k cycles, k = lowest set bit of div_sel_i.
module fib_step_div #(
  parameter int unsigned CLOCK_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [CLOCK_WIDTH-1:0] div_sel_i,
  output logic                   tick_o
);

  logic [CLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic [CLOCK_WIDTH-1:0] last_cnt;
  logic                   sel_any;

  // Scan downward so the lowest set bit is the one that sticks.
  always_comb begin
    last_cnt = '0;
    for (int k = CLOCK_WIDTH - 1; k >= 0; k--) begin
      if (div_sel_i[k]) begin
        last_cnt = CLOCK_WIDTH'((32'd1 << k) - 32'd1);
      end
    end
  end

  assign sel_any = |div_sel_i;
  // >= so that shrinking the period below the current count ticks at once.
  assign tick_o  = enable_i && sel_any && (cnt_q >= last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && sel_any) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Fibonacci controller: owns the (a, b) term pair and step index, sequences commands,
// paces steps via fib_step_div and halts on target or on term overflow.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH       = 30,
  parameter int unsigned CLOCK_WIDTH = 6,
  parameter int unsigned IDX_WIDTH   = 16
) (
  input  logic             wb_clk_i,
  input  logic             reset,
  fib_sequencer_if.slave   bus
);

  fib_state_e           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 irq_q, irq_d;

  logic [WIDTH:0]       sum;
  logic [IDX_WIDTH-1:0] idx_inc;
  logic                 do_step;
  logic                 halt_set;
  logic                 is_clear;
  logic                 div_clear;
  logic                 tick;

  assign is_clear  = bus.cmd_valid && (bus.cmd_op == OP_CLEAR);
  assign div_clear = is_clear || (bus.cmd_valid && (bus.cmd_op == OP_START) &&
                                  (state_q == ST_IDLE));

  fib_step_div #(
    .CLOCK_WIDTH (CLOCK_WIDTH)
  ) u_step_div (
    .clk_i     (wb_clk_i),
    .reset     (reset),
    .enable_i  (state_q == ST_RUN),
    .clear_i   (div_clear),
    .div_sel_i (bus.div_sel),
    .tick_o    (tick)
  );

  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    irq_d      = irq_q;
    do_step    = 1'b0;
    halt_set   = 1'b0;

    // Any command in a cycle swallows a coincident divider tick.
    if (bus.cmd_valid) begin
      unique case (bus.cmd_op)
        OP_CLEAR: begin
          state_d    = ST_IDLE;
          a_d        = '0;
          b_d        = WIDTH'(1);
          idx_d      = '0;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
          ovf_pend_d = 1'b0;
        end
        OP_START: if (state_q == ST_IDLE) state_d = ST_RUN;
        OP_STOP:  if (state_q == ST_RUN)  state_d = ST_IDLE;
        OP_STEP:  do_step = (state_q == ST_IDLE);
        default: ;
      endcase
    end else if (tick) begin
      do_step = 1'b1;
    end

    if (do_step) begin
      if (ovf_pend_q) begin
        // b already wrapped on the previous step, so refuse to advance.
        ovf_d    = 1'b1;
        state_d  = ST_HALT;
        halt_set = 1'b1;
      end else begin
        a_d        = b_q;
        b_d        = sum[WIDTH-1:0];
        ovf_pend_d = sum[WIDTH];
        idx_d      = idx_inc;
        if ((bus.target != '0) && (idx_inc == bus.target)) begin
          done_d   = 1'b1;
          state_d  = ST_HALT;
          halt_set = 1'b1;
        end
      end
    end

    if (is_clear) begin
      irq_d = 1'b0;
    end else if (halt_set) begin
      irq_d = 1'b1;
    end else if (bus.irq_clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= WIDTH'(1);
      idx_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      irq_q      <= irq_d;
    end
  end

  // Masked so status reads 0 throughout reset, even before the first edge.
  assign bus.fib_value = reset ? '0 : a_q;
  assign bus.fib_index = reset ? '0 : idx_q;
  assign bus.busy      = !reset && (state_q == ST_RUN);
  assign bus.done      = !reset && done_q;
  assign bus.overflow  = !reset && ovf_q;
  assign bus.irq       = !reset && irq_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer with a queue scoreboard of expected status snapshots.
module tb_fib_sequencer;
  import fib_pkg::*;

  localparam int unsigned W  = 30;
  localparam int unsigned CW = 6;
  localparam int unsigned IW = 16;

  logic clk = 1'b0;
  logic rst;

  fib_sequencer_if #(.WIDTH(W), .CLOCK_WIDTH(CW), .IDX_WIDTH(IW)) bus ();

  fib_sequencer #(
    .WIDTH       (W),
    .CLOCK_WIDTH (CW),
    .IDX_WIDTH   (IW)
  ) dut (
    .wb_clk_i (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  val;
    logic [IW-1:0] idx;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          irq;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [W-1:0] fib(int n);
    logic [31:0] x, y, t;
    x = 0;
    y = 1;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  task automatic push(input logic [W-1:0] val, input int idx, input logic busy,
                      input logic done, input logic ovf, input logic irq);
    exp_t e;
    e.val  = val;
    e.idx  = IW'(idx);
    e.busy = busy;
    e.done = done;
    e.ovf  = ovf;
    e.irq  = irq;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".value"},    32'(bus.fib_value), 32'(e.val));
      cmp({tag, ".index"},    32'(bus.fib_index), 32'(e.idx));
      cmp({tag, ".busy"},     32'(bus.busy),      32'(e.busy));
      cmp({tag, ".done"},     32'(bus.done),      32'(e.done));
      cmp({tag, ".overflow"}, 32'(bus.overflow),  32'(e.ovf));
      cmp({tag, ".irq"},      32'(bus.irq),       32'(e.irq));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input fib_op_e op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    cycles(1);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_CLEAR;
    bus.div_sel   = '0;
    bus.target    = '0;
    bus.irq_clr   = 1'b0;

    cycles(2);
    push(0, 0, 0, 0, 0, 0); check("in_reset");
    rst = 1'b0;
    cycles(1);
    push(0, 0, 0, 0, 0, 0); check("after_reset");

    // Single steps in IDLE.
    for (int i = 1; i <= 5; i++) begin
      push(fib(i), i, 0, 0, 0, 0);
      cmd(OP_STEP);
      check($sformatf("step%0d", i));
    end

    // Period 4, target 10; irq_clr coincides with the halting edge.
    push(0, 0, 0, 0, 0, 0); cmd(OP_CLEAR); check("clear_a");
    bus.div_sel = 6'b000100;
    bus.target  = 16'd10;
    push(0, 0, 1, 0, 0, 0); cmd(OP_START); check("start_p4");
    push(0, 0, 1, 0, 0, 0); cycles(3); check("p4_before_tick");
    push(1, 1, 1, 0, 0, 0); cycles(1); check("p4_tick1");
    push(fib(9), 9, 1, 0, 0, 0); cycles(35); check("p4_idx9");
    bus.irq_clr = 1'b1;
    push(55, 10, 0, 1, 0, 1); cycles(1); check("target_halt_irq_wins");
    push(55, 10, 0, 1, 0, 0); cycles(1); check("irq_clr");
    bus.irq_clr = 1'b0;
    push(55, 10, 0, 1, 0, 0); cmd(OP_START); check("start_in_halt");
    push(55, 10, 0, 1, 0, 0); cmd(OP_STEP);  check("step_in_halt");

    // Period 1 run into overflow.
    push(0, 0, 0, 0, 0, 0); cmd(OP_CLEAR); check("clear_b");
    bus.div_sel = 6'b000001;
    bus.target  = '0;
    push(0, 0, 1, 0, 0, 0); cmd(OP_START); check("start_p1");
    push(fib(44), 44, 1, 0, 0, 0); cycles(44); check("idx44");
    push(30'd701408733, 44, 0, 0, 1, 1); cycles(1); check("overflow_halt");

    // STOP lands on a tick edge (period 1), then resume.
    push(0, 0, 0, 0, 0, 0); cmd(OP_CLEAR); check("clear_c");
    push(0, 0, 1, 0, 0, 0); cmd(OP_START); check("start_c");
    push(2, 3, 1, 0, 0, 0); cycles(3); check("three_steps");
    push(2, 3, 0, 0, 0, 0); cmd(OP_STOP);  check("stop_beats_tick");
    push(2, 3, 1, 0, 0, 0); cmd(OP_START); check("restart");
    push(3, 4, 1, 0, 0, 0); cycles(1); check("resume_step");

    // Reset while running.
    rst = 1'b1;
    push(0, 0, 0, 0, 0, 0); cycles(1); check("reset_mid_run");
    rst = 1'b0;
    push(0, 0, 0, 0, 0, 0); cycles(1); check("idle_after_reset");

    // No div select: RUN without steps.
    bus.div_sel = '0;
    push(0, 0, 1, 0, 0, 0); cmd(OP_START); check("start_nodiv");
    push(0, 0, 1, 0, 0, 0); cycles(100); check("no_ticks_100");

    // Count reaches 10 at period 32, then shrinking to period 1 ticks next edge.
    bus.div_sel = 6'b100000;
    push(0, 0, 1, 0, 0, 0); cycles(10); check("p32_no_tick");
    bus.div_sel = 6'b000001;
    push(1, 1, 1, 0, 0, 0); cycles(1); check("rate_change_tick");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
